kd_sort_sched: RTL
==================

// Module: kd_sort_sched
// PURPOSE
// Top-level scheduler for the kd-tree node array. Sequences one clustering round at the root node:
// configure sort (axis), repeat sort passes until the tree reports stable, then stream points into the root.
// Sits between the point source/host and the root node's command port; one command outstanding at a time.
// PARAMETERS
// DATA_W      32    command payload / point width
// AXIS_W      2     sorting-axis field width
// CMD_W       3     command code width
// PCNT_W      16    point-count width
// MAX_PASSES  16    sort passes allowed before declaring error
// TIMEOUT     1024  cycles allowed waiting for any ack
// PORTS
// clk          in   1        clock
// rst          in   1        synchronous active-high reset
// start        in   1        begin round (sampled in IDLE/ERR only)
// num_points   in   PCNT_W   points to stream this round (latched at start)
// init_axis    in   AXIS_W   root sorting axis (latched at start)
// point_valid  in   1        point source has data
// point_data   in   DATA_W   point
// point_ready  out  1        scheduler accepts point
// cmd_valid    out  1        command to root valid
// cmd_ready    in   1        root accepts command
// cmd          out  CMD_W    0 NOP, 1 CONFIGURE_SORT, 2 START_SORT, 3 SEND_POINT
// cmd_data     out  DATA_W   payload: CONFIGURE={0..,init_axis}; SEND_POINT=point; else 0
// ack_valid    in   1        ack from root (1-cycle pulse)
// ack_cmd      in   CMD_W    command code being acked
// ack_stable   in   1        with START_SORT ack: no swaps occurred in tree
// busy         out  1        round in progress
// done         out  1        1-cycle pulse: round complete
// error        out  1        sticky: bad ack, timeout, or pass limit
// pass_count   out  5        sort passes completed this round (saturates at 31)
// BEHAVIOUR
// - Reset: cmd_valid=0, cmd=NOP, cmd_data=0, point_ready=0, busy=0, done=0, error=0, pass_count=0, state=IDLE.
// - States: IDLE, CFG_SEND, CFG_WAIT, SORT_SEND, SORT_WAIT, PT_FETCH, PT_SEND, PT_WAIT, DONE, ERR.
// - IDLE/ERR: start=1 -> latch inputs, clear error/pass_count/point counter, go CFG_SEND next cycle.
// - *_SEND: cmd_valid=1 with cmd/cmd_data stable until cmd_valid&cmd_ready; then *_WAIT, watchdog=0.
// - *_WAIT: cmd_valid=0; watchdog increments each cycle. ack_valid with ack_cmd==pending code -> proceed.
//   ack_valid with any other code -> ERR. watchdog==TIMEOUT-1 without ack -> ERR. Ack on that cycle wins.
// - CFG_WAIT ack -> SORT_SEND.
// - SORT_WAIT ack: pass_count+1. ack_stable=1 -> PT_FETCH (or DONE if num_points==0);
//   else if passes done == MAX_PASSES -> ERR; else SORT_SEND.
// - PT_FETCH: point_ready=1; point_valid -> capture point_data, point_ready=0 next cycle, go PT_SEND.
// - PT_WAIT ack: points_sent+1; points_sent==num_points -> DONE else PT_FETCH.
// - DONE: done=1 for exactly one cycle, -> IDLE.
// - busy=1 in every state except IDLE and ERR. error=1 only in ERR.
// - start while busy ignored; ack_valid in IDLE/SEND/FETCH/DONE ignored (no error).
// - Min latency per command: 1 cycle SEND (cmd_ready=1) + 1 cycle to ack = 2 cycles.
// - rst mid-round: return to reset values next edge; no command left asserted.
// TESTING
// 1) start, axis=2, num_points=3, root acks next cycle, stable on pass 1 -> CONFIGURE data=2, 1 START_SORT,
//    3 SEND_POINT in source order, done pulse once, pass_count=1, error=0.
// 2) ack_stable=0 for passes 1-2, 1 on 3 -> exactly 3 START_SORT issued, pass_count=3, then points.
// 3) ack_stable never 1, MAX_PASSES=16 -> 16 START_SORT then ERR, error=1, busy=0; start restarts cleanly.
// 4) cmd_ready low 5 cycles on CONFIGURE -> cmd/cmd_data held stable, single transfer; no ack for
//    TIMEOUT cycles in SORT_WAIT -> error=1; ack arriving on cycle TIMEOUT-1 -> no error.
// 5) SORT_WAIT receives ack_cmd=SEND_POINT -> ERR; num_points=0 -> done right after stable, no SEND_POINT.
// 6) rst asserted during PT_WAIT with cmd_valid high earlier -> all outputs reset values next cycle.

Source files
------------

// File: rtl/kd_sort_sched.sv
// kd_sort_sched
//   Root-node round scheduler for the kd-tree node array. One round is:
//   CONFIGURE_SORT(axis), then START_SORT passes until the tree reports a
//   pass with no swaps, then one SEND_POINT per point from the source.
//   Only one command is ever outstanding toward the root.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   start                begin a round (honoured only in IDLE or ERR)
//   num_points/init_axis round parameters, latched on start
//   point_valid/_ready   point source handshake, point_data payload
//   cmd_valid/_ready     command handshake toward the root; cmd, cmd_data
//   ack_valid/ack_cmd    single-cycle ack pulse from the root
//   ack_stable           qualifies a START_SORT ack: no swaps this pass
//   busy                 round in progress
//   done                 single-cycle pulse at end of a good round
//   error                held while parked in ERR (bad ack, timeout, pass limit)
//   pass_count           sort passes completed this round, saturating at 31
module kd_sort_sched #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned AXIS_W     = 2,
  parameter int unsigned CMD_W      = 3,
  parameter int unsigned PCNT_W     = 16,
  parameter int unsigned MAX_PASSES = 16,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [PCNT_W-1:0] num_points,
  input  logic [AXIS_W-1:0] init_axis,
  input  logic              point_valid,
  input  logic [DATA_W-1:0] point_data,
  output logic              point_ready,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [CMD_W-1:0]  cmd,
  output logic [DATA_W-1:0] cmd_data,
  input  logic              ack_valid,
  input  logic [CMD_W-1:0]  ack_cmd,
  input  logic              ack_stable,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [4:0]        pass_count
);

  localparam int unsigned WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned PS_W = $clog2(MAX_PASSES + 1);

  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(MAX_PASSES - 1);

  localparam logic [CMD_W-1:0] CMD_NOP  = CMD_W'(0);
  localparam logic [CMD_W-1:0] CMD_CFG  = CMD_W'(1);
  localparam logic [CMD_W-1:0] CMD_SORT = CMD_W'(2);
  localparam logic [CMD_W-1:0] CMD_PT   = CMD_W'(3);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CFG_SEND,
    S_CFG_WAIT,
    S_SORT_SEND,
    S_SORT_WAIT,
    S_PT_FETCH,
    S_PT_SEND,
    S_PT_WAIT,
    S_DONE,
    S_ERR
  } state_t;

  state_t              state_q, state_d;
  logic [AXIS_W-1:0]   axis_q, axis_d;
  logic [PCNT_W-1:0]   npts_q, npts_d;
  logic [PCNT_W-1:0]   sent_q, sent_d;
  logic [DATA_W-1:0]   pt_q, pt_d;
  logic [WD_W-1:0]     wdog_q, wdog_d;
  logic [PS_W-1:0]     passes_q, passes_d;
  logic [4:0]          pcnt_q, pcnt_d;
  logic [CMD_W-1:0]    pend_code;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      axis_q   <= '0;
      npts_q   <= '0;
      sent_q   <= '0;
      pt_q     <= '0;
      wdog_q   <= '0;
      passes_q <= '0;
      pcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      axis_q   <= axis_d;
      npts_q   <= npts_d;
      sent_q   <= sent_d;
      pt_q     <= pt_d;
      wdog_q   <= wdog_d;
      passes_q <= passes_d;
      pcnt_q   <= pcnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    axis_d      = axis_q;
    npts_d      = npts_q;
    sent_d      = sent_q;
    pt_d        = pt_q;
    wdog_d      = wdog_q;
    passes_d    = passes_q;
    pcnt_d      = pcnt_q;
    cmd_valid   = 1'b0;
    cmd         = CMD_NOP;
    cmd_data    = '0;
    point_ready = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    error       = 1'b0;

    // Code the root must echo back while we sit in a *_WAIT state.
    unique case (state_q)
      S_CFG_WAIT:  pend_code = CMD_CFG;
      S_SORT_WAIT: pend_code = CMD_SORT;
      S_PT_WAIT:   pend_code = CMD_PT;
      default:     pend_code = CMD_NOP;
    endcase

    unique case (state_q)
      S_IDLE, S_ERR: begin
        busy  = 1'b0;
        error = (state_q == S_ERR);
        if (start) begin
          axis_d   = init_axis;
          npts_d   = num_points;
          sent_d   = '0;
          passes_d = '0;
          pcnt_d   = '0;
          state_d  = S_CFG_SEND;
        end
      end

      S_CFG_SEND: begin
        cmd_valid = 1'b1;
        cmd       = CMD_CFG;
        cmd_data  = DATA_W'(axis_q);
        if (cmd_ready) begin
          wdog_d  = '0;
          state_d = S_CFG_WAIT;
        end
      end

      S_SORT_SEND: begin
        cmd_valid = 1'b1;
        cmd       = CMD_SORT;
        if (cmd_ready) begin
          wdog_d  = '0;
          state_d = S_SORT_WAIT;
        end
      end

      S_PT_FETCH: begin
        point_ready = 1'b1;
        if (point_valid) begin
          pt_d    = point_data;
          state_d = S_PT_SEND;
        end
      end

      S_PT_SEND: begin
        cmd_valid = 1'b1;
        cmd       = CMD_PT;
        cmd_data  = pt_q;
        if (cmd_ready) begin
          wdog_d  = '0;
          state_d = S_PT_WAIT;
        end
      end

      S_CFG_WAIT, S_SORT_WAIT, S_PT_WAIT: begin
        wdog_d = wdog_q + 1'b1;
        // An ack is checked before the watchdog so a matching ack on the
        // final allowed cycle still counts as success.
        if (ack_valid) begin
          if (ack_cmd != pend_code) begin
            state_d = S_ERR;
          end else if (state_q == S_CFG_WAIT) begin
            state_d = S_SORT_SEND;
          end else if (state_q == S_SORT_WAIT) begin
            passes_d = passes_q + 1'b1;
            pcnt_d   = (pcnt_q == 5'd31) ? pcnt_q : pcnt_q + 5'd1;
            if (ack_stable) begin
              state_d = (npts_q == '0) ? S_DONE : S_PT_FETCH;
            end else if (passes_q == PS_LAST) begin
              state_d = S_ERR;
            end else begin
              state_d = S_SORT_SEND;
            end
          end else begin
            sent_d  = sent_q + 1'b1;
            state_d = (sent_d == npts_q) ? S_DONE : S_PT_FETCH;
          end
        end else if (wdog_q == WD_LAST) begin
          state_d = S_ERR;
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign pass_count = pcnt_q;

endmodule
